mem_arbiter: RTL and testbench

//   Two-requester arbiter/sequencer for the single shared unified memory of the

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges instruction-fetch (IF) and load/store (LS) requests onto
// the single shared memory port and sequences the registered-read latency.
// One access in flight; LS has priority unless IF has waited STARVE_LIMIT
// consecutive LS grants.
//
// Handshake: a requester raises *_req with a stable payload and keeps it until
// the matching *_gnt pulse (ACCESS cycle). Reads complete with a one-cycle
// *_rvalid pulse; *_rdata mirrors mem_rdata and is only meaningful with it.
module mem_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [2:0]  ls_funct3,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_owner_ls;
  logic        r_is_store;
  logic [3:0]  r_starve;
  logic [2:0]  r_lat;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;

  logic w_any_req;
  logic w_pick_ls;
  logic w_last_wait;

  assign w_any_req   = if_req | ls_req;
  // LS wins unless IF is waiting and has already been passed over the limit.
  assign w_pick_ls   = ls_req & ~(if_req & (r_starve == 4'(STARVE_LIMIT)));
  assign w_last_wait = (r_state == ST_WAIT) && (r_lat == 3'd1);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode and strobe outputs, all derived from registered state.
  always_comb begin
    w_next    = r_state;
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    mem_we    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if_gnt = ~r_owner_ls;
        ls_gnt = r_owner_ls;
        mem_we = r_owner_ls & r_is_store;
        w_next = r_is_store ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (w_last_wait) begin
          if_rvalid = ~r_owner_ls;
          ls_rvalid = r_owner_ls;
          w_next    = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Capture winner payload, track starvation and count read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner_ls <= 1'b0;
      r_is_store <= 1'b0;
      r_starve   <= 4'd0;
      r_lat      <= 3'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_funct3   <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!if_req)        r_starve <= 4'd0;
          else if (w_pick_ls) begin
            if (r_starve != 4'(STARVE_LIMIT)) r_starve <= r_starve + 4'd1;
          end else            r_starve <= 4'd0;
          if (w_any_req) begin
            r_owner_ls <= w_pick_ls;
            r_is_store <= w_pick_ls & ls_we;
            if (w_pick_ls) begin
              r_addr   <= ls_addr;
              r_wdata  <= ls_wdata;
              r_funct3 <= ls_funct3;
            end else begin
              // Fetches are always full words; write data is left untouched.
              r_addr   <= if_addr;
              r_funct3 <= 3'b010;
            end
          end
        end
        ST_ACCESS: r_lat <= 3'(READ_LATENCY);
        ST_WAIT:   r_lat <= r_lat - 3'd1;
        default:   r_lat <= 3'd0;
      endcase
    end
  end

  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_funct3 = r_funct3;
  assign if_rdata   = mem_rdata;
  assign ls_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (READ_LATENCY 1 / STARVE_LIMIT 4 and
// READ_LATENCY 3 / STARVE_LIMIT 2) driven by independent random requesters
// that obey the hold-until-grant rule, each compared every cycle against a
// timeline model (grant/valid/free cycle numbers) plus a read scoreboard.
module tb_mem_arbiter;

  logic clk;
  logic rst;

  logic        if_req[2];
  logic [31:0] if_addr[2];
  logic        if_gnt[2];
  logic        if_rvalid[2];
  logic [31:0] if_rdata[2];
  logic        ls_req[2];
  logic        ls_we[2];
  logic [31:0] ls_addr[2];
  logic [31:0] ls_wdata[2];
  logic [2:0]  ls_funct3[2];
  logic        ls_gnt[2];
  logic        ls_rvalid[2];
  logic [31:0] ls_rdata[2];
  logic        mem_we[2];
  logic [31:0] mem_addr[2];
  logic [31:0] mem_wdata[2];
  logic [2:0]  mem_funct3[2];
  logic [31:0] mem_rdata[2];

  mem_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(4)) u_dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .ls_req(ls_req[0]), .ls_we(ls_we[0]), .ls_addr(ls_addr[0]),
    .ls_wdata(ls_wdata[0]), .ls_funct3(ls_funct3[0]), .ls_gnt(ls_gnt[0]),
    .ls_rvalid(ls_rvalid[0]), .ls_rdata(ls_rdata[0]),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_funct3(mem_funct3[0]), .mem_rdata(mem_rdata[0])
  );

  mem_arbiter #(.READ_LATENCY(3), .STARVE_LIMIT(2)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .ls_req(ls_req[1]), .ls_we(ls_we[1]), .ls_addr(ls_addr[1]),
    .ls_wdata(ls_wdata[1]), .ls_funct3(ls_funct3[1]), .ls_gnt(ls_gnt[1]),
    .ls_rvalid(ls_rvalid[1]), .ls_rdata(ls_rdata[1]),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_funct3(mem_funct3[1]), .mem_rdata(mem_rdata[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int p_if = 0, p_ls = 0, p_we = 50;
  logic rel_pending = 1'b0;

  // Model parameters per instance.
  int rl[2]  = '{1, 3};
  int lim[2] = '{4, 2};

  // Timeline model: cycle of grant, cycle of rvalid, first cycle free again.
  int          g_t[2], v_t[2], free_t[2], m_starve[2];
  logic        m_own_ls[2], m_store[2];
  logic [31:0] m_addr[2], m_wdata[2];
  logic [2:0]  m_f3[2];
  logic        seen_if_gnt[2], seen_ls_gnt[2];
  int          n_gnt[2], n_rv[2];

  // Read scoreboard: {owner_is_ls, address} per accepted read.
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset(input int k);
    g_t[k] = -1; v_t[k] = -1; free_t[k] = 0; m_starve[k] = 0;
    m_own_ls[k] = 1'b0; m_store[k] = 1'b0;
    m_addr[k] = '0; m_wdata[k] = '0; m_f3[k] = '0;
    seen_if_gnt[k] = 1'b0; seen_ls_gnt[k] = 1'b0;
    if (k == 0) exp_q0.delete(); else exp_q1.delete();
  endtask

  task automatic check_zero(input int k);
    string d;
    d = $sformatf("d%0d_rst_", k);
    check({d, "if_gnt"},    32'(if_gnt[k]),    32'd0);
    check({d, "ls_gnt"},    32'(ls_gnt[k]),    32'd0);
    check({d, "if_rvalid"}, 32'(if_rvalid[k]), 32'd0);
    check({d, "ls_rvalid"}, 32'(ls_rvalid[k]), 32'd0);
    check({d, "mem_we"},    32'(mem_we[k]),    32'd0);
    check({d, "mem_addr"},  mem_addr[k],       32'd0);
    check({d, "mem_wdata"}, mem_wdata[k],      32'd0);
    check({d, "mem_funct3"}, 32'(mem_funct3[k]), 32'd0);
  endtask

  // One cycle of comparison followed by the model's own arbitration step.
  task automatic model_cycle(input int k);
    string d;
    logic  e_acc, e_val, pick_ls;
    logic [32:0] ent;
    d = $sformatf("d%0d_", k);
    if (!rst) begin
      check_zero(k);
      model_reset(k);
      return;
    end
    e_acc = (cyc == g_t[k]);
    e_val = (cyc == v_t[k]);
    check({d, "if_gnt"},    32'(if_gnt[k]),    32'(e_acc & ~m_own_ls[k]));
    check({d, "ls_gnt"},    32'(ls_gnt[k]),    32'(e_acc & m_own_ls[k]));
    check({d, "mem_we"},    32'(mem_we[k]),    32'(e_acc & m_own_ls[k] & m_store[k]));
    check({d, "if_rvalid"}, 32'(if_rvalid[k]), 32'(e_val & ~m_own_ls[k]));
    check({d, "ls_rvalid"}, 32'(ls_rvalid[k]), 32'(e_val & m_own_ls[k]));
    check({d, "mem_addr"},  mem_addr[k],       m_addr[k]);
    check({d, "mem_wdata"}, mem_wdata[k],      m_wdata[k]);
    check({d, "mem_funct3"}, 32'(mem_funct3[k]), 32'(m_f3[k]));
    if (if_gnt[k] || ls_gnt[k]) n_gnt[k]++;
    // Scoreboard side: whatever the DUT returns must match the oldest read.
    if (if_rvalid[k] || ls_rvalid[k]) begin
      n_rv[k]++;
      if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
        check({d, "sb_unexpected_rvalid"}, 32'd1, 32'd0);
      end else begin
        ent = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check({d, "sb_owner"}, 32'(ls_rvalid[k]), 32'(ent[32]));
        check({d, "sb_addr"},  mem_addr[k], ent[31:0]);
        if (ls_rvalid[k]) check({d, "ls_rdata"}, ls_rdata[k], mem_rdata[k]);
        else              check({d, "if_rdata"}, if_rdata[k], mem_rdata[k]);
      end
    end
    seen_if_gnt[k] = if_gnt[k];
    seen_ls_gnt[k] = ls_gnt[k];
    // Arbitration happens only when the previous access has fully retired.
    if (cyc >= free_t[k]) begin
      if (!if_req[k]) m_starve[k] = 0;
      if (if_req[k] || ls_req[k]) begin
        pick_ls = ls_req[k] && !(if_req[k] && m_starve[k] == lim[k]);
        if (if_req[k]) m_starve[k] = pick_ls ? ((m_starve[k] < lim[k]) ? m_starve[k] + 1 : lim[k]) : 0;
        m_own_ls[k] = pick_ls;
        m_store[k]  = pick_ls && ls_we[k];
        m_addr[k]   = pick_ls ? ls_addr[k] : if_addr[k];
        m_f3[k]     = pick_ls ? ls_funct3[k] : 3'b010;
        if (pick_ls) m_wdata[k] = ls_wdata[k];
        g_t[k] = cyc + 1;
        if (m_store[k]) begin
          v_t[k] = -1;
          free_t[k] = cyc + 2;
        end else begin
          v_t[k] = cyc + 1 + rl[k];
          free_t[k] = cyc + 2 + rl[k];
          if (k == 0) exp_q0.push_back({pick_ls, m_addr[k]});
          else        exp_q1.push_back({pick_ls, m_addr[k]});
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  // Requesters only change a raised request after seeing its grant.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rel_pending) begin
      rst = 1'b1;
      rel_pending = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      if (!if_req[k] || seen_if_gnt[k]) begin
        if_req[k]  = ($urandom_range(99) < p_if);
        if_addr[k] = $urandom;
      end
      if (!ls_req[k] || seen_ls_gnt[k]) begin
        ls_req[k]    = ($urandom_range(99) < p_ls);
        ls_we[k]     = ($urandom_range(99) < p_we);
        ls_addr[k]   = $urandom;
        ls_wdata[k]  = $urandom;
        ls_funct3[k] = 3'($urandom_range(7));
      end
      mem_rdata[k] = $urandom;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) model_cycle(k);
  endtask

  task automatic run(input int n, input int pi, input int pl, input int pw);
    p_if = pi; p_ls = pl; p_we = pw;
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 0; if_addr[k] = '0; ls_req[k] = 0; ls_we[k] = 0;
      ls_addr[k] = '0; ls_wdata[k] = '0; ls_funct3[k] = '0; mem_rdata[k] = '0;
      n_gnt[k] = 0; n_rv[k] = 0;
      model_reset(k);
    end
    run(3, 0, 0, 0);
    rel_pending = 1'b1;
    run(20, 100, 0, 0);     // fetch-only reads
    run(20, 0, 100, 100);   // back-to-back stores
    run(60, 100, 100, 50);  // both saturated: starvation forcing
    run(800, 50, 50, 50);   // random mix

    // Abort a load in flight: line up an LS load, then reset inside its WAIT.
    p_if = 0; p_ls = 100; p_we = 0;
    begin
      int budget = 0;
      while (!seen_ls_gnt[1] && budget < 50) begin
        step();
        budget++;
      end
      check("ls_gnt_before_reset_timeout", 32'(seen_ls_gnt[1]), 32'd1);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_zero(k);
      model_reset(k);
    end
    run(3, 0, 0, 0);
    rel_pending = 1'b1;
    run(15, 100, 0, 0);     // fresh fetches after reset
    run(300, 60, 60, 40);
    run(20, 0, 0, 0);       // drain

    for (int k = 0; k < 2; k++) begin
      check($sformatf("d%0d_sb_drained", k),
            32'(k == 0 ? exp_q0.size() : exp_q1.size()), 32'd0);
      check($sformatf("d%0d_traffic_gnt", k), 32'(n_gnt[k] > 100), 32'd1);
      check($sformatf("d%0d_traffic_rv", k),  32'(n_rv[k] > 30),   32'd1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
